// File: rtl/ibex_instr_resp_pkg.sv
// Shared types and helpers for the instruction-bus responder.
// A response is the read word plus an error flag.
package ibex_instr_resp_pkg;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } instr_resp_t;

    localparam instr_resp_t RespErr = '{rdata: 32'h0, err: 1'b1};

    // Evaluated in 34 bits so a window ending at 2^32 does not wrap.
    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int unsigned depth);
        logic [33:0] a;
        logic [33:0] lo;
        logic [33:0] hi;
        a  = {2'b00, addr};
        lo = {2'b00, base};
        hi = lo + ({2'b00, 32'(depth)} << 2);
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/ibex_instr_resp_fifo.sv
// Small synchronous FIFO of bus responses, synchronous active-high reset.
// Depth need not be a power of two; pointers wrap explicitly.
module ibex_instr_resp_fifo
    import ibex_instr_resp_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  instr_resp_t                  data_i,
    input  logic                         pop_i,
    output instr_resp_t                  data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(Depth+1)-1:0]   count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    instr_resp_t     mem [Depth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [CntW-1:0] count;

    // NOTE: the storage array has no reset; count alone decides which entries are live.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_i) begin
                rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign data_o  = mem[rd_ptr];
    assign full_o  = (count == FullCnt);
    assign empty_o = (count == '0);
    assign count_o = count;

endmodule

// File: rtl/ibex_instr_bus_responder.sv
// Responder for the core instruction-fetch bus in front of a 1-cycle SRAM.
// Throttles grants by outstanding count and buffers responses under stall.
module ibex_instr_bus_responder
    import ibex_instr_resp_pkg::*;
#(
    parameter int unsigned MemDepthWords  = 1024,
    parameter logic [31:0] BaseAddr       = 32'h0000_0000,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             instr_req_i,
    input  logic [31:0]                      instr_addr_i,
    output logic                             instr_gnt_o,
    output logic                             instr_rvalid_o,
    output logic [31:0]                      instr_rdata_o,
    output logic                             instr_err_o,
    input  logic                             gnt_stall_i,
    input  logic                             resp_stall_i,
    output logic                             sram_req_o,
    output logic [$clog2(MemDepthWords)-1:0] sram_addr_o,
    input  logic [31:0]                      sram_rdata_i,
    output logic                             busy_o
);

    localparam int unsigned AddrW  = $clog2(MemDepthWords);
    localparam int unsigned CntW   = $clog2(MaxOutstanding + 1);
    localparam int unsigned CntW1  = CntW + 1;
    localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

    logic [CntW-1:0] out_cnt;
    logic            addr_ok;
    logic [31:0]     addr_offset;
    logic            s1_valid;
    logic            s1_err;
    instr_resp_t     s1_resp;
    instr_resp_t     fifo_head;
    instr_resp_t     resp_out;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CntW-1:0] fifo_count;
    logic            bypass;

    // Grant is purely combinational on req; a retiring rvalid frees credit only next cycle.
    assign addr_ok     = in_range(instr_addr_i, BaseAddr, MemDepthWords);
    assign addr_offset = instr_addr_i - BaseAddr;
    assign instr_gnt_o = ~rst_i & instr_req_i & ~gnt_stall_i & (out_cnt < CntMax);
    assign sram_req_o  = instr_gnt_o & addr_ok;
    assign sram_addr_o = AddrW'(addr_offset >> 2);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
        end else begin
            s1_valid <= instr_gnt_o;
            s1_err   <= instr_gnt_o & ~addr_ok;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        s1_resp   = '{rdata: sram_rdata_i, err: 1'b0};
        bypass    = 1'b0;
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        resp_out  = '0;
        if (s1_err) begin
            s1_resp = RespErr;
        end
        if (!rst_i) begin
            fifo_pop  = ~fifo_empty & ~resp_stall_i;
            bypass    = s1_valid & fifo_empty & ~resp_stall_i;
            fifo_push = s1_valid & ~bypass;
            if (fifo_pop) begin
                resp_out = fifo_head;
            end else if (bypass) begin
                resp_out = s1_resp;
            end
        end
    end

    ibex_instr_resp_fifo #(
        .Depth (MaxOutstanding)
    ) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .data_i  (s1_resp),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign instr_rvalid_o = fifo_pop | bypass;
    assign instr_rdata_o  = resp_out.rdata;
    assign instr_err_o    = resp_out.err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_cnt <= '0;
        end else begin
            case ({instr_gnt_o, instr_rvalid_o})
                2'b10:   out_cnt <= out_cnt + 1'b1;
                2'b01:   out_cnt <= out_cnt - 1'b1;
                default: out_cnt <= out_cnt;
            endcase
        end
    end

    assign busy_o = ~rst_i & (out_cnt != '0);

    // The out_cnt bound guarantees the buffer never overflows.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(fifo_push && fifo_full));

    a_rvalid_has_credit: assert property (@(posedge clk_i) disable iff (rst_i)
        instr_rvalid_o |-> (out_cnt != '0));

    a_inflight_bounded: assert property (@(posedge clk_i) disable iff (rst_i)
        ({1'b0, fifo_count} + CntW1'(s1_valid)) <= {1'b0, out_cnt});

endmodule

// File: tb/tb_ibex_instr_bus_responder.sv
// Scoreboard bench: driver queues expected responses on grant, monitor checks rvalid.
module tb_ibex_instr_bus_responder;

    localparam int unsigned MemDepthWords  = 1024;
    localparam logic [31:0] BaseAddr       = 32'h8000_0000;
    localparam int unsigned MaxOutstanding = 2;
    localparam int unsigned AddrW          = $clog2(MemDepthWords);

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
        bit          chk_lat;
        int          gnt_cyc;
    } txn_t;

    logic             clk_i;
    logic             rst_i;
    logic             instr_req_i;
    logic [31:0]      instr_addr_i;
    logic             instr_gnt_o;
    logic             instr_rvalid_o;
    logic [31:0]      instr_rdata_o;
    logic             instr_err_o;
    logic             gnt_stall_i;
    logic             resp_stall_i;
    logic             sram_req_o;
    logic [AddrW-1:0] sram_addr_o;
    logic [31:0]      sram_rdata_i;
    logic             busy_o;

    logic [31:0] tb_mem [MemDepthWords];
    txn_t        stim_q[$];
    txn_t        exp_q[$];
    bit          drv_en;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    ibex_instr_bus_responder #(
        .MemDepthWords  (MemDepthWords),
        .BaseAddr       (BaseAddr),
        .MaxOutstanding (MaxOutstanding)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .instr_err_o    (instr_err_o),
        .gnt_stall_i    (gnt_stall_i),
        .resp_stall_i   (resp_stall_i),
        .sram_req_o     (sram_req_o),
        .sram_addr_o    (sram_addr_o),
        .sram_rdata_i   (sram_rdata_i),
        .busy_o         (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // SRAM model: 1-cycle read latency, poison value when not read.
    initial begin
        for (int i = 0; i < int'(MemDepthWords); i++) tb_mem[i] = 32'hC0DE_0000 | i;
        tb_mem[4]    = 32'hDEAD_BEEF;
        tb_mem[1023] = 32'h1234_5678;
    end
    always @(posedge clk_i) sram_rdata_i <= sram_req_o ? tb_mem[sram_addr_o] : 32'hBAD0_BAD0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_stim(input logic [31:0] addr, input logic [31:0] data,
                             input logic err, input bit chk_lat);
        txn_t t;
        t.addr    = addr;
        t.data    = data;
        t.err     = err;
        t.chk_lat = chk_lat;
        t.gnt_cyc = 0;
        stim_q.push_back(t);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((stim_q.size() != 0 || exp_q.size() != 0) && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check({name, " drain timeout"}, 32'(n >= 50), 32'd0);
        @(negedge clk_i);
        check({name, " busy after drain"}, 32'(busy_o), 32'd0);
    endtask

    // Driver: present head of stim_q; on grant move it to the scoreboard.
    initial begin
        instr_req_i  = 1'b0;
        instr_addr_i = '0;
        forever begin
            @(posedge clk_i);
            #2;
            instr_req_i = drv_en && (stim_q.size() != 0);
            if (instr_req_i) instr_addr_i = stim_q[0].addr;
            @(negedge clk_i);
            if (instr_req_i && instr_gnt_o) begin
                txn_t t;
                t = stim_q.pop_front();
                t.gnt_cyc = cyc;
                exp_q.push_back(t);
            end
        end
    end

    // Monitor: every rvalid must match the oldest granted request.
    always @(negedge clk_i) begin : monitor
        txn_t e;
        if (instr_rvalid_o) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected rvalid: got rdata %h err %b, required no response (cycle %0d)",
                         instr_rdata_o, instr_err_o, cyc);
            end else begin
                e = exp_q.pop_front();
                check("resp rdata", instr_rdata_o, e.data);
                check("resp err", 32'(instr_err_o), 32'(e.err));
                if (e.chk_lat) check("resp latency", 32'(cyc - e.gnt_cyc), 32'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        rst_i        = 1'b1;
        gnt_stall_i  = 1'b0;
        resp_stall_i = 1'b0;
        drv_en       = 1'b0;

        // Reset: request pending but everything held low.
        @(posedge clk_i); #1;
        push_stim(BaseAddr + 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1);
        drv_en = 1'b1;
        repeat (2) begin
            @(negedge clk_i);
            check("rst gnt", 32'(instr_gnt_o), 32'd0);
            check("rst sram_req", 32'(sram_req_o), 32'd0);
            check("rst rvalid", 32'(instr_rvalid_o), 32'd0);
            check("rst rdata", instr_rdata_o, 32'd0);
            check("rst err", 32'(instr_err_o), 32'd0);
            check("rst busy", 32'(busy_o), 32'd0);
        end

        // Single fetch of word 4.
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("single gnt", 32'(instr_gnt_o), 32'd1);
        check("single sram_req", 32'(sram_req_o), 32'd1);
        check("single sram_addr", 32'(sram_addr_o), 32'd4);
        @(negedge clk_i);
        check("single rvalid", 32'(instr_rvalid_o), 32'd1);
        check("single busy t+1", 32'(busy_o), 32'd1);
        @(negedge clk_i);
        check("single busy t+2", 32'(busy_o), 32'd0);
        check("single rvalid t+2", 32'(instr_rvalid_o), 32'd0);

        // Back-to-back fetches: grant every cycle.
        @(posedge clk_i); #1;
        push_stim(BaseAddr + 32'h0, 32'hC0DE_0000, 1'b0, 1'b1);
        push_stim(BaseAddr + 32'h4, 32'hC0DE_0001, 1'b0, 1'b1);
        push_stim(BaseAddr + 32'h8, 32'hC0DE_0002, 1'b0, 1'b1);
        push_stim(BaseAddr + 32'hC, 32'hC0DE_0003, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("b2b gnt", 32'(instr_gnt_o), 32'd1);
        end
        wait_idle("b2b");

        // Range boundaries: one past the top, one below base, last word.
        @(posedge clk_i); #1;
        push_stim(BaseAddr + 32'h1000, 32'h0, 1'b1, 1'b1);
        push_stim(BaseAddr - 32'h4, 32'h0, 1'b1, 1'b1);
        push_stim(BaseAddr + 32'hFFC, 32'h1234_5678, 1'b0, 1'b1);
        @(negedge clk_i);
        check("oor top gnt", 32'(instr_gnt_o), 32'd1);
        check("oor top sram_req", 32'(sram_req_o), 32'd0);
        @(negedge clk_i);
        check("oor low gnt", 32'(instr_gnt_o), 32'd1);
        check("oor low sram_req", 32'(sram_req_o), 32'd0);
        @(negedge clk_i);
        check("last word sram_req", 32'(sram_req_o), 32'd1);
        check("last word sram_addr", 32'(sram_addr_o), 32'd1023);
        wait_idle("range");

        // Response stall for 5 cycles with continuous requests.
        @(posedge clk_i); #1;
        resp_stall_i = 1'b1;
        push_stim(BaseAddr + 32'h20, 32'hC0DE_0008, 1'b0, 1'b0);
        push_stim(BaseAddr + 32'h24, 32'hC0DE_0009, 1'b0, 1'b0);
        push_stim(BaseAddr + 32'h28, 32'hC0DE_000A, 1'b0, 1'b1);
        push_stim(BaseAddr + 32'h2C, 32'hC0DE_000B, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("stall gnt", 32'(instr_gnt_o), 32'(i < 2));
            check("stall rvalid", 32'(instr_rvalid_o), 32'd0);
        end
        @(posedge clk_i); #1;
        resp_stall_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("release gnt", 32'(instr_gnt_o), 32'(i != 0));
            check("release rvalid", 32'(instr_rvalid_o), 32'd1);
        end
        wait_idle("stall");

        // Grant stall for 3 cycles.
        @(posedge clk_i); #1;
        gnt_stall_i = 1'b1;
        push_stim(BaseAddr + 32'h30, 32'hC0DE_000C, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("gstall gnt", 32'(instr_gnt_o), 32'd0);
            check("gstall sram_req", 32'(sram_req_o), 32'd0);
        end
        @(posedge clk_i); #1;
        gnt_stall_i = 1'b0;
        @(negedge clk_i);
        check("gstall release gnt", 32'(instr_gnt_o), 32'd1);
        wait_idle("gstall");

        // Reset with two responses buffered.
        @(posedge clk_i); #1;
        resp_stall_i = 1'b1;
        push_stim(BaseAddr + 32'h40, 32'hC0DE_0010, 1'b0, 1'b0);
        push_stim(BaseAddr + 32'h44, 32'hC0DE_0011, 1'b0, 1'b0);
        @(negedge clk_i);
        @(negedge clk_i);
        @(negedge clk_i);
        check("pre-rst busy", 32'(busy_o), 32'd1);
        check("pre-rst rvalid", 32'(instr_rvalid_o), 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        exp_q.delete();
        stim_q.delete();
        @(negedge clk_i);
        check("mid-rst rvalid", 32'(instr_rvalid_o), 32'd0);
        @(posedge clk_i); #1;
        rst_i        = 1'b0;
        resp_stall_i = 1'b0;
        @(negedge clk_i);
        check("post-rst rvalid", 32'(instr_rvalid_o), 32'd0);
        check("post-rst busy", 32'(busy_o), 32'd0);
        @(posedge clk_i); #1;
        push_stim(BaseAddr + 32'h14, 32'hC0DE_0005, 1'b0, 1'b1);
        @(negedge clk_i);
        check("post-rst gnt", 32'(instr_gnt_o), 32'd1);
        wait_idle("post-rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ibex_instr_bus_responder.md
# ibex_instr_bus_responder

Responder end of the core instruction-fetch bus (req/gnt/rvalid with in-order, non-backpressurable responses). Sits between the core fetch interface and a single-port synchronous instruction SRAM with 1-cycle read latency. It provides grant/response throttling, address-range error responses, and a response buffer, and serves as the standard instruction memory model for simulation and FPGA top levels.

## Interface
Parameters:
- `MemDepthWords`, 1024: SRAM depth in 32-bit words; power of two.
- `BaseAddr`, 32'h0000_0000: byte address of word 0; aligned to `4*MemDepthWords`.
- `MaxOutstanding`, 2: granted requests without rvalid; range 1..4.

Ports (one clock; reset is synchronous and active-high):
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous active-high reset.
- `instr_req_i` in 1: fetch request.
- `instr_addr_i` in 32: request byte address; bits [1:0] ignored.
- `instr_gnt_o` out 1: request accepted this cycle.
- `instr_rvalid_o` out 1: response valid; initiator cannot stall.
- `instr_rdata_o` out 32: response data; 0 when err.
- `instr_err_o` out 1: bus error; valid only with rvalid.
- `gnt_stall_i` in 1: test/arbiter hook; forces gnt low.
- `resp_stall_i` in 1: test hook; holds responses in buffer.
- `sram_req_o` out 1: SRAM read strobe.
- `sram_addr_o` out log2(MemDepthWords): word index.
- `sram_rdata_i` in 32: read data, valid the cycle after `sram_req_o`.
- `busy_o` out 1: any request in flight or buffered.

## Operation
- Address check: in range iff `BaseAddr <= addr < BaseAddr + 4*MemDepthWords`. Index = `(addr - BaseAddr) >> 2`.
- Grant: `instr_gnt_o = instr_req_i & ~gnt_stall_i & (out_cnt < MaxOutstanding)`. The grant is combinational on req. No same-cycle credit from a retiring rvalid.
- `out_cnt`: increments on gnt and decrements on rvalid; both in one cycle leaves it unchanged. Width is `$clog2(MaxOutstanding+1)`.
- On an in-range gnt, `sram_req_o=1` in the same cycle. On an out-of-range gnt there is no SRAM access.
- Stage-1 register (`s1_valid`, `s1_err`) is loaded on every gnt and cleared otherwise.
- Response source in the cycle after gnt: `{sram_rdata_i, 0}`, or `{32'h0, 1}` if `s1_err`.
- Response buffer: a FIFO of depth `MaxOutstanding` holding `{rdata, err}`.
  - If the FIFO is empty and `resp_stall_i` is low, the stage-1 response bypasses to the outputs (rvalid this cycle).
  - Otherwise the stage-1 response is pushed.
  - While non-empty and not stalled, the FIFO head is popped onto the outputs; a stage-1 response arriving the same cycle is pushed behind it.
- Responses are strictly in grant order. Overflow is impossible by the `out_cnt` bound, and an assertion checks it.
- `busy_o = (out_cnt != 0)`.

## Timing
- Reset values: `instr_gnt_o` follows comb. logic (0 while `rst_i`). `instr_rvalid_o=0`, `instr_rdata_o=0`, `instr_err_o=0`, `sram_req_o=0`, `busy_o=0`. `out_cnt`, `s1_valid` and the FIFO are cleared.
- During `rst_i=1`, gnt and sram_req are forced 0.
- Latency: gnt in cycle t gives rvalid earliest in cycle t+1, for both data and error responses.
- Throughput: 1 word/cycle for `MaxOutstanding>=2`. For `MaxOutstanding=1`, 1 word per 2 cycles.
- `resp_stall_i` asserted for n cycles delays the affected responses by n cycles. Grants continue until `out_cnt == MaxOutstanding`.
- Reset mid-operation: all in-flight and buffered responses are dropped, with no rvalid in the cycle after reset deasserts. The initiator is reset together with this block.
- `instr_addr_i` is only sampled on gnt. req dropped without gnt is legal.

## Structure
- Package `ibex_instr_resp_pkg`: `instr_resp_t` struct `{logic [31:0] rdata; logic err;}`, and function `in_range(addr, base, depth)`.
- Sub-module `ibex_instr_resp_fifo`: parameterised sync-reset FIFO of `instr_resp_t` with push/pop/full/empty/count.
- Top: grant logic, `out_cnt`, stage-1 register, bypass mux, assertions (no overflow; no rvalid when `out_cnt==0`).

## Test plan
- Single in-range fetch at `BaseAddr+0x10`, SRAM word 4 = 32'hDEAD_BEEF: gnt in cycle t; rvalid in t+1 with `rdata=DEADBEEF`, `err=0`; `busy_o` low in t+2.
- Back-to-back req to 0x0, 0x4, 0x8, 0xC with `MaxOutstanding=2`: gnt every cycle; rvalid every cycle from t+1; data in order.
- Address `BaseAddr + 4*MemDepthWords`: gnt, `sram_req_o=0`, rvalid in t+1 with `err=1`, `rdata=0`.
- `resp_stall_i` high for 5 cycles while requesting continuously: exactly `MaxOutstanding` gnts, then gnt held 0. After release, buffered responses come on consecutive cycles in order, then grants resume.
- `gnt_stall_i` high for 3 cycles with req high: no gnt and no sram_req. gnt occurs on the first cycle after the stall.
- Assert `rst_i` with 2 responses buffered: next cycle rvalid=0 and `busy_o=0`. A fresh fetch after reset returns correct data with latency 1.
